duck_round_manager: RTL and testbench
=====================================

DUCK_ROUND_MANAGER -- requirements
Module: duck_round_manager

Interface
REQ-001 Parameter DUCKS_PER_ROUND, default 10, ducks spawned per round; legal range 1..15.
REQ-002 Parameter HITS_TO_PASS, default 6, minimum hits per round to advance; legal range 1..DUCKS_PER_ROUND.
REQ-003 Parameter MAX_ROUNDS, default 9, last round number; legal range 1..15.
REQ-004 Parameter INTERMISSION_CYCLES, default 65_000_000, length of the between-round pause in clk cycles (must be >= 1).
REQ-005 clk  in  1  system clock; single clock domain.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 game_enable  in  1  high while the game-control FSM is in its game state.
REQ-008 duck_hit  in  1  one-cycle pulse: the current duck was shot.
REQ-009 duck_escaped  in  1  one-cycle pulse: the current duck left the screen or ran out of bullets.
REQ-010 spawn_duck  out  1  one-cycle pulse requesting the game logic launch a new duck.
REQ-011 round_number  out  4  current round, 1-based; 0 when idle.
REQ-012 hits_in_round  out  4  hits scored in the current round.
REQ-013 ducks_left  out  4  ducks not yet resolved in the current round.
REQ-014 hit_flags  out  16  bit i = 1 when duck i (0-based) of the current round was hit; used by the HUD.
REQ-015 intermission  out  1  high during the between-round pause.
REQ-016 game_finished  out  1  level; drives the game_finished input of the game-control FSM.
REQ-017 game_won  out  1  valid while game_finished=1: 1 = all rounds passed, 0 = failed round.

Function
REQ-018 The FSM SHALL have states IDLE, SPAWN, ACTIVE, ROUND_END, INTERMISSION and GAME_OVER.
REQ-019 IDLE: all outputs 0; on game_enable=1, load round_number=1, ducks_left=DUCKS_PER_ROUND, clear hits and flags, go to SPAWN.
REQ-020 SPAWN: assert spawn_duck for exactly one cycle, go to ACTIVE next cycle.
REQ-021 ACTIVE: on duck_hit, increment hits_in_round, set hit_flags[duck index], decrement ducks_left.
REQ-022 ACTIVE: on duck_escaped without duck_hit, decrement ducks_left only.
REQ-023 duck_hit and duck_escaped in the same cycle SHALL be counted once, as a hit.
REQ-024 After a resolved duck, ducks_left reaching 0 SHALL go to ROUND_END; otherwise go to SPAWN (next spawn_duck two cycles after the resolving pulse).
REQ-025 duck_hit/duck_escaped outside ACTIVE SHALL be ignored.
REQ-026 ROUND_END (one cycle): hits_in_round < HITS_TO_PASS -> GAME_OVER with game_won=0; else round_number = MAX_ROUNDS -> GAME_OVER with game_won=1; else INTERMISSION.
REQ-027 INTERMISSION: intermission=1; hold hits_in_round and hit_flags for display; a down-counter SHALL run exactly INTERMISSION_CYCLES cycles.
REQ-028 At intermission expiry: round_number+1, hits_in_round=0, hit_flags=0, ducks_left=DUCKS_PER_ROUND, intermission=0, go to SPAWN.
REQ-029 GAME_OVER: game_finished=1 and game_won held stable; the state persists until game_enable=0.
REQ-030 game_enable=0 in any non-IDLE state SHALL return to IDLE next cycle, clearing all counters and outputs (abort).
REQ-031 Counters SHALL never wrap: hits_in_round <= DUCKS_PER_ROUND, ducks_left >= 0, and round_number <= MAX_ROUNDS.
REQ-032 All outputs SHALL be registered; no combinational path from inputs to outputs.
REQ-033 Duck index for hit_flags = DUCKS_PER_ROUND - ducks_left, evaluated before the decrement.

Reset
REQ-034 rst=1 SHALL force IDLE, all outputs 0, intermission counter 0, on the next clk edge, regardless of state.
REQ-035 Reset mid-round or mid-intermission SHALL discard all progress; leaving reset with game_enable=1 starts round 1 via SPAWN.

Verification
REQ-036 Params 3/2/2/4. Rise game_enable -> spawn_duck pulse 1 cycle after entering SPAWN; round_number=1, ducks_left=3.
REQ-037 Hit, hit, escape -> hit_flags=0b011, hits=2, then ROUND_END -> intermission=1 for exactly 4 cycles -> round_number=2, hits=0, flags=0, spawn_duck.
REQ-038 Round 1: hit, escape, escape -> game_finished=1, game_won=0; holds until game_enable=0, then all outputs 0.
REQ-039 Round 2 passed (2 hits) with MAX_ROUNDS=2 -> game_finished=1, game_won=1, no intermission.
REQ-040 duck_hit and duck_escaped asserted together -> hits+1, ducks_left-1 once. Pulses during SPAWN or INTERMISSION -> no counter change.
REQ-041 game_enable dropped mid-ACTIVE, and rst asserted mid-INTERMISSION -> IDLE next cycle, all outputs 0; restart begins at round 1.

Source files
------------

// File: rtl/duck_round_manager.sv
// Round sequencer for the duck-shooting game: spawns ducks, scores hits per round,
// runs the between-round pause and reports the final win/lose outcome.
module duck_round_manager #(
    parameter int DUCKS_PER_ROUND     = 10,
    parameter int HITS_TO_PASS        = 6,
    parameter int MAX_ROUNDS          = 9,
    parameter int INTERMISSION_CYCLES = 65_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        game_enable,
    input  logic        duck_hit,
    input  logic        duck_escaped,
    output logic        spawn_duck,
    output logic [3:0]  round_number,
    output logic [3:0]  hits_in_round,
    output logic [3:0]  ducks_left,
    output logic [15:0] hit_flags,
    output logic        intermission,
    output logic        game_finished,
    output logic        game_won
);

    // The pause counter only ever holds INTERMISSION_CYCLES-1 down to 0.
    localparam int              CNT_W      = (INTERMISSION_CYCLES > 1) ? $clog2(INTERMISSION_CYCLES) : 1;
    localparam logic [CNT_W-1:0] INTER_LOAD = CNT_W'(INTERMISSION_CYCLES - 1);
    localparam logic [3:0]      DUCKS_LOAD = 4'(DUCKS_PER_ROUND);
    localparam logic [3:0]      HITS_PASS  = 4'(HITS_TO_PASS);
    localparam logic [3:0]      LAST_ROUND = 4'(MAX_ROUNDS);

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_SPAWN        = 3'd1,
        ST_ACTIVE       = 3'd2,
        ST_ROUND_END    = 3'd3,
        ST_INTERMISSION = 3'd4,
        ST_GAME_OVER    = 3'd5
    } state_t;

    state_t           state_r;
    logic             spawn_r;
    logic [3:0]       round_r;
    logic [3:0]       hits_r;
    logic [3:0]       ducks_r;
    logic [15:0]      flags_r;
    logic             inter_r;
    logic             finished_r;
    logic             won_r;
    logic [CNT_W-1:0] inter_cnt_r;

    logic             resolved_s;
    logic [3:0]       hits_inc_s;
    logic [3:0]       ducks_dec_s;
    logic [3:0]       round_inc_s;
    logic [15:0]      flag_mask_s;

    // The duck being resolved is indexed by how many ducks of the round came before it.
    function automatic logic [15:0] flag_for_duck(input logic [3:0] left);
        logic [3:0] idx;
        idx = DUCKS_LOAD - left;
        return 16'd1 << idx;
    endfunction

    // Saturating next-values so no counter can ever wrap.
    always_comb begin
        resolved_s  = duck_hit | duck_escaped;
        flag_mask_s = flag_for_duck(ducks_r);
        if (hits_r < DUCKS_LOAD) begin
            hits_inc_s = hits_r + 4'd1;
        end else begin
            hits_inc_s = hits_r;
        end
        if (ducks_r != 4'd0) begin
            ducks_dec_s = ducks_r - 4'd1;
        end else begin
            ducks_dec_s = 4'd0;
        end
        if (round_r < LAST_ROUND) begin
            round_inc_s = round_r + 4'd1;
        end else begin
            round_inc_s = round_r;
        end
    end

    // Round FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (rst || (state_r != ST_IDLE && !game_enable)) begin
            state_r     <= ST_IDLE;
            spawn_r     <= 1'b0;
            round_r     <= 4'd0;
            hits_r      <= 4'd0;
            ducks_r     <= 4'd0;
            flags_r     <= 16'd0;
            inter_r     <= 1'b0;
            finished_r  <= 1'b0;
            won_r       <= 1'b0;
            inter_cnt_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    spawn_r     <= 1'b0;
                    hits_r      <= 4'd0;
                    flags_r     <= 16'd0;
                    inter_r     <= 1'b0;
                    finished_r  <= 1'b0;
                    won_r       <= 1'b0;
                    inter_cnt_r <= '0;
                    if (game_enable) begin
                        round_r <= 4'd1;
                        ducks_r <= DUCKS_LOAD;
                        state_r <= ST_SPAWN;
                    end else begin
                        round_r <= 4'd0;
                        ducks_r <= 4'd0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_SPAWN: begin
                    spawn_r <= 1'b1;
                    state_r <= ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    spawn_r <= 1'b0;
                    if (resolved_s) begin
                        // A simultaneous hit and escape is scored once, as a hit.
                        if (duck_hit) begin
                            hits_r  <= hits_inc_s;
                            flags_r <= flags_r | flag_mask_s;
                        end else begin
                            hits_r  <= hits_r;
                            flags_r <= flags_r;
                        end
                        ducks_r <= ducks_dec_s;
                        if (ducks_dec_s == 4'd0) begin
                            state_r <= ST_ROUND_END;
                        end else begin
                            state_r <= ST_SPAWN;
                        end
                    end else begin
                        state_r <= ST_ACTIVE;
                    end
                end
                ST_ROUND_END: begin
                    if (hits_r < HITS_PASS) begin
                        finished_r <= 1'b1;
                        won_r      <= 1'b0;
                        state_r    <= ST_GAME_OVER;
                    end else if (round_r >= LAST_ROUND) begin
                        finished_r <= 1'b1;
                        won_r      <= 1'b1;
                        state_r    <= ST_GAME_OVER;
                    end else begin
                        inter_r     <= 1'b1;
                        inter_cnt_r <= INTER_LOAD;
                        state_r     <= ST_INTERMISSION;
                    end
                end
                ST_INTERMISSION: begin
                    if (inter_cnt_r == '0) begin
                        inter_r <= 1'b0;
                        round_r <= round_inc_s;
                        hits_r  <= 4'd0;
                        flags_r <= 16'd0;
                        ducks_r <= DUCKS_LOAD;
                        state_r <= ST_SPAWN;
                    end else begin
                        inter_cnt_r <= inter_cnt_r - 1'b1;
                        state_r     <= ST_INTERMISSION;
                    end
                end
                ST_GAME_OVER: begin
                    state_r <= ST_GAME_OVER;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    spawn_r     <= 1'b0;
                    round_r     <= 4'd0;
                    hits_r      <= 4'd0;
                    ducks_r     <= 4'd0;
                    flags_r     <= 16'd0;
                    inter_r     <= 1'b0;
                    finished_r  <= 1'b0;
                    won_r       <= 1'b0;
                    inter_cnt_r <= '0;
                end
            endcase
        end
    end

    assign spawn_duck    = spawn_r;
    assign round_number  = round_r;
    assign hits_in_round = hits_r;
    assign ducks_left    = ducks_r;
    assign hit_flags     = flags_r;
    assign intermission  = inter_r;
    assign game_finished = finished_r;
    assign game_won      = won_r;

endmodule

// File: tb/tb_duck_round_manager.sv
// Directed bench for duck_round_manager with 3 ducks, 2 hits to pass, 2 rounds, 4-cycle pause.
module tb_duck_round_manager;

    logic        clk;
    logic        rst;
    logic        game_enable;
    logic        duck_hit;
    logic        duck_escaped;
    logic        spawn_duck;
    logic [3:0]  round_number;
    logic [3:0]  hits_in_round;
    logic [3:0]  ducks_left;
    logic [15:0] hit_flags;
    logic        intermission;
    logic        game_finished;
    logic        game_won;

    int vectors;
    int miscompares;
    int inter_len;

    duck_round_manager #(
        .DUCKS_PER_ROUND    (3),
        .HITS_TO_PASS       (2),
        .MAX_ROUNDS         (2),
        .INTERMISSION_CYCLES(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .game_enable  (game_enable),
        .duck_hit     (duck_hit),
        .duck_escaped (duck_escaped),
        .spawn_duck   (spawn_duck),
        .round_number (round_number),
        .hits_in_round(hits_in_round),
        .ducks_left   (ducks_left),
        .hit_flags    (hit_flags),
        .intermission (intermission),
        .game_finished(game_finished),
        .game_won     (game_won)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {spawn_duck, round_number, hits_in_round, ducks_left, hit_flags,
                intermission, game_finished, game_won};
    endfunction

    task automatic pulse(input logic h, input logic e);
        duck_hit     = h;
        duck_escaped = e;
        tick();
        duck_hit     = 1'b0;
        duck_escaped = 1'b0;
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst          = 1'b1;
        game_enable  = 1'b0;
        duck_hit     = 1'b0;
        duck_escaped = 1'b0;
        tick();
        tick();
        chk("reset_outs", all_outs(), 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_outs", all_outs(), 32'd0);

        // Start: enter SPAWN, pulses during SPAWN are ignored.
        game_enable = 1'b1;
        tick();
        chk("start_spawn_low", {31'd0, spawn_duck}, 32'd0);
        chk("start_round", {28'd0, round_number}, 32'd1);
        chk("start_ducks", {28'd0, ducks_left}, 32'd3);
        pulse(1'b1, 1'b1);
        chk("spawn_pulse", {31'd0, spawn_duck}, 32'd1);
        chk("spawn_ignore", {hits_in_round, ducks_left}, {24'd0, 4'd0, 4'd3});

        // Round 1: hit, hit+escape together, escape.
        pulse(1'b1, 1'b0);
        chk("r1_hit1", {hits_in_round, ducks_left, hit_flags}, {8'd0, 4'd1, 4'd2, 16'h0001});
        chk("r1_spawn_low", {31'd0, spawn_duck}, 32'd0);
        tick();
        chk("r1_respawn", {31'd0, spawn_duck}, 32'd1);
        pulse(1'b1, 1'b1);
        chk("r1_both", {hits_in_round, ducks_left, hit_flags}, {8'd0, 4'd2, 4'd1, 16'h0003});
        tick();
        pulse(1'b0, 1'b1);
        chk("r1_escape", {hits_in_round, ducks_left, hit_flags}, {8'd0, 4'd2, 4'd0, 16'h0003});
        chk("r1_no_inter_yet", {31'd0, intermission}, 32'd0);
        tick();
        chk("inter_start", {27'd0, intermission, round_number}, {27'd0, 1'b1, 4'd1});

        // Pause: count its length while trying to hit, which must be ignored.
        inter_len = 0;
        duck_hit  = 1'b1;
        while (intermission === 1'b1 && inter_len < 20) begin
            inter_len++;
            chk("inter_hold", {hits_in_round, hit_flags}, {12'd0, 4'd2, 16'h0003});
            tick();
        end
        duck_hit = 1'b0;
        chk("inter_len", inter_len, 32'd4);
        chk("r2_load", {round_number, hits_in_round, ducks_left, hit_flags},
            {4'd0, 4'd2, 4'd0, 4'd3, 16'h0000});
        tick();
        chk("r2_spawn", {31'd0, spawn_duck}, 32'd1);

        // Round 2 passed on the last round: win, no pause.
        pulse(1'b1, 1'b0);
        tick();
        pulse(1'b0, 1'b1);
        chk("r2_flags", {hits_in_round, ducks_left, hit_flags}, {8'd0, 4'd1, 4'd1, 16'h0001});
        tick();
        pulse(1'b1, 1'b0);
        chk("r2_done", {hits_in_round, ducks_left, hit_flags}, {8'd0, 4'd2, 4'd0, 16'h0005});
        tick();
        chk("win", {29'd0, intermission, game_finished, game_won}, 32'd3);
        tick();
        tick();
        chk("win_hold", {29'd0, intermission, game_finished, game_won}, 32'd3);
        game_enable = 1'b0;
        tick();
        chk("win_release", all_outs(), 32'd0);

        // Failed round 1: one hit only.
        game_enable = 1'b1;
        tick();
        tick();
        pulse(1'b1, 1'b0);
        tick();
        pulse(1'b0, 1'b1);
        tick();
        pulse(1'b0, 1'b1);
        tick();
        chk("lose", {26'd0, round_number, game_finished, game_won}, {26'd0, 4'd1, 1'b1, 1'b0});
        tick();
        tick();
        tick();
        chk("lose_hold", {30'd0, game_finished, game_won}, 32'd2);
        game_enable = 1'b0;
        tick();
        chk("lose_release", all_outs(), 32'd0);

        // Abort mid-ACTIVE, then restart.
        game_enable = 1'b1;
        tick();
        tick();
        pulse(1'b1, 1'b0);
        tick();
        game_enable = 1'b0;
        tick();
        chk("abort", all_outs(), 32'd0);
        game_enable = 1'b1;
        tick();
        chk("abort_restart", {round_number, hits_in_round, ducks_left, hit_flags},
            {4'd0, 4'd1, 4'd0, 4'd3, 16'h0000});

        // Reset mid-pause, leaving reset with game_enable high restarts round 1.
        tick();
        pulse(1'b1, 1'b0);
        tick();
        pulse(1'b1, 1'b0);
        tick();
        pulse(1'b0, 1'b1);
        tick();
        tick();
        chk("rst_inter_on", {31'd0, intermission}, 32'd1);
        rst = 1'b1;
        tick();
        chk("rst_mid_inter", all_outs(), 32'd0);
        rst = 1'b0;
        tick();
        chk("rst_restart", {round_number, hits_in_round, ducks_left, hit_flags},
            {4'd0, 4'd1, 4'd0, 4'd3, 16'h0000});
        tick();
        chk("rst_restart_spawn", {31'd0, spawn_duck}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
